// File: rtl/lcd_rx_pkg.sv
// lcd_rx_pkg: shared types, constants and decode helpers for the LCD bus receiver.
package lcd_rx_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, BUSY} lcd_rx_state_t;
    typedef enum logic [3:0] {
        INS_NONE, INS_CLEAR, INS_HOME, INS_ENTRY, INS_DISPLAY,
        INS_SHIFT, INS_FUNCTION, INS_CGRAM, INS_DDRAM
    } lcd_instr_t;
    localparam logic [7:0] LCD_SPACE   = 8'h20;
    localparam logic [6:0] ROW1_BASE   = 7'h40;
    localparam int         DDRAM_DEPTH = 32;
    function automatic lcd_instr_t instr_class(input logic [7:0] d);
        if (d[7]) return INS_DDRAM;
        if (d[6]) return INS_CGRAM;
        if (d[5]) return INS_FUNCTION;
        if (d[4]) return INS_SHIFT;
        if (d[3]) return INS_DISPLAY;
        if (d[2]) return INS_ENTRY;
        if (d[1]) return INS_HOME;
        if (d[0]) return INS_CLEAR;
        return INS_NONE;
    endfunction
    // Row select comes from A[6]; anything in A[5:4] lies outside the visible 2x16 window.
    function automatic logic [4:0] ddram_index(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction
    function automatic logic ddram_addr_bad(input logic [6:0] a);
        return (a & ~ROW1_BASE) > 7'h0F;
    endfunction
endpackage

// File: rtl/lcd_ddram.sv
// lcd_ddram: 32x8 display RAM, async reset to spaces, one write port, combinational read.
module lcd_ddram
    import lcd_rx_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic [4:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] mem [DDRAM_DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DDRAM_DEPTH; i++) mem[i] <= LCD_SPACE;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: HD44780-style write-bus decoder into a 32-char display RAM.
// Define LCD_BUSY_CHECK_EN to add the post-instruction BUSY window and busy-violation flagging.
module lcd_bus_receiver
    import lcd_rx_pkg::*;
#(
    parameter int EXEC_CYCLES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        lcd_e,
    input  logic        lcd_rs,
    input  logic        lcd_rw,
    input  logic [7:0]  lcd_data,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [4:0]  cursor,
    output logic        display_on,
    output logic        two_line,
    output logic        busy,
    output logic        proto_err,
    output logic [15:0] wr_count
);
`ifdef LCD_BUSY_CHECK_EN
    localparam bit BUSY_CHECK = 1'b1;
`else
    localparam bit BUSY_CHECK = 1'b0;
`endif
    localparam int CNT_W = $clog2(EXEC_CYCLES + 1);

    lcd_rx_state_t state;
    logic          e_q, rs_q, rw_q;
    logic [7:0]    data_q;
    logic          inc_mode;
    logic [4:0]    clr_idx;
    logic [CNT_W-1:0] cnt;
    logic          fall, data_wr, clearing;
    lcd_instr_t    ins;
    logic [4:0]    cur_step;

    assign fall     = e_q & ~lcd_e;
    assign clearing = state == CLEAR;
    assign data_wr  = fall & (state == IDLE) & ~rw_q & rs_q;
    assign ins      = rs_q ? INS_NONE : instr_class(data_q);
    assign cur_step = inc_mode ? cursor + 5'd1 : cursor - 5'd1;

    // The clear sweep owns the write port; bus data writes cannot occur outside IDLE.
    lcd_ddram u_ddram (
        .clk   (clk),
        .resetn(resetn),
        .we    (clearing | data_wr),
        .waddr (clearing ? clr_idx : cursor),
        .wdata (clearing ? LCD_SPACE : data_q),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            data_q     <= 8'h00;
            cursor     <= 5'd0;
            inc_mode   <= 1'b1;
            clr_idx    <= 5'd0;
            cnt        <= '0;
            display_on <= 1'b0;
            two_line   <= 1'b0;
            busy       <= 1'b0;
            proto_err  <= 1'b0;
            wr_count   <= 16'h0000;
        end else begin
            e_q <= lcd_e;
            if (lcd_e) begin
                rs_q   <= lcd_rs;
                rw_q   <= lcd_rw;
                data_q <= lcd_data;
            end
            case (state)
                IDLE: if (fall) begin
                    if (rw_q) begin
                        proto_err <= 1'b1;
                    end else if (rs_q) begin
                        wr_count <= wr_count + 16'd1;
                        cursor   <= cur_step;
                    end else begin
                        case (ins)
                            INS_CLEAR: begin
                                state    <= CLEAR;
                                busy     <= 1'b1;
                                cursor   <= 5'd0;
                                inc_mode <= 1'b1;
                                clr_idx  <= 5'd0;
                            end
                            INS_HOME:     cursor     <= 5'd0;
                            INS_ENTRY:    inc_mode   <= data_q[1];
                            INS_DISPLAY:  display_on <= data_q[2];
                            INS_SHIFT:    if (!data_q[3]) cursor <= data_q[2] ? cursor + 5'd1 : cursor - 5'd1;
                            INS_FUNCTION: two_line   <= data_q[3];
                            INS_DDRAM: begin
                                cursor <= ddram_index(data_q[6:0]);
                                if (ddram_addr_bad(data_q[6:0])) proto_err <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    if (BUSY_CHECK && !rw_q && (rs_q || ins != INS_CLEAR)) begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        cnt   <= CNT_W'(EXEC_CYCLES - 1);
                    end
                end
                CLEAR: begin
                    clr_idx <= clr_idx + 5'd1;
                    if (clr_idx == 5'd31) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    if (BUSY_CHECK && fall) proto_err <= 1'b1;
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                    if (BUSY_CHECK && fall) proto_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
